// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel-array readout path.
package pixel_pkg;

    localparam int PIXEL_BITS = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } readout_state_t;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

endpackage : pixel_pkg

// File: rtl/pixel_readout.sv
// Consumer end of the pixel-array output bus. Captures one full frame into a
// shadow register on a capture strobe, then streams it out one pixel per
// valid/ready handshake in row-major order with first/row-end/last markers.
module pixel_readout
    import pixel_pkg::*;
#(
    parameter int W = 3,
    parameter int H = 2,
    parameter int N = H * W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PIXEL_BITS*N-1:0] pixel_data_in,
    input  logic                    capture,
    output logic [PIXEL_BITS-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_first,
    output logic                    out_row_end,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic [15:0]             frame_count
);

    // Counter widths never drop below one bit so single-pixel/column/row
    // configurations still elaborate.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);

    readout_state_t          state_r;
    readout_state_t          state_n_s;
    logic [PIXEL_BITS*N-1:0] shadow_r;
    logic [IDX_W-1:0]        idx_r;
    logic [COL_W-1:0]        col_r;
    logic [ROW_W-1:0]        row_r;
    logic                    overrun_r;
    logic [15:0]             frame_count_r;

    logic                    valid_s;
    logic                    handshake_s;
    logic                    at_last_s;
    logic                    load_s;
    logic                    advance_s;
    logic                    frame_done_s;
    logic                    overrun_set_s;

    pixel_t                  pixel_s [N];

    // Unpack the shadow frame into per-pixel bytes; pixel k sits at [8k+7:8k].
    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign pixel_s[k] = shadow_r[PIXEL_BITS*k +: PIXEL_BITS];
    end

    assign valid_s     = (state_r == STREAM);
    assign handshake_s = valid_s && out_ready;
    assign at_last_s   = (idx_r == IDX_LAST);

    // Next-state and datapath control decode.
    always_comb begin
        state_n_s     = state_r;
        load_s        = 1'b0;
        advance_s     = 1'b0;
        frame_done_s  = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (capture) begin
                    load_s    = 1'b1;
                    state_n_s = STREAM;
                end else begin
                    state_n_s = IDLE;
                end
            end
            STREAM: begin
                if (handshake_s && at_last_s) begin
                    frame_done_s = 1'b1;
                    // A capture on the final handshake reloads with no bubble.
                    if (capture) begin
                        load_s    = 1'b1;
                        state_n_s = STREAM;
                    end else begin
                        state_n_s = IDLE;
                    end
                end else begin
                    if (handshake_s) begin
                        advance_s = 1'b1;
                    end else begin
                        advance_s = 1'b0;
                    end
                    // The held frame is still draining, so a new one is dropped.
                    if (capture) begin
                        overrun_set_s = 1'b1;
                    end else begin
                        overrun_set_s = 1'b0;
                    end
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Shadow frame, pixel position counters, overrun flag and frame counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_r      <= '0;
            idx_r         <= '0;
            col_r         <= '0;
            row_r         <= '0;
            overrun_r     <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            if (load_s) begin
                shadow_r <= pixel_data_in;
            end

            if (load_s || frame_done_s) begin
                idx_r <= '0;
                col_r <= '0;
                row_r <= '0;
            end else if (advance_s) begin
                idx_r <= idx_r + IDX_W'(1);
                if (col_r == COL_LAST) begin
                    col_r <= '0;
                    row_r <= row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end

            // Set has priority over clear so a coincident drop is not lost.
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr) begin
                overrun_r <= 1'b0;
            end

            if (frame_done_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign out_valid   = valid_s;
    assign busy        = valid_s;
    assign out_data    = valid_s ? pixel_s[idx_r] : '0;
    assign out_first   = valid_s && (idx_r == '0);
    assign out_row_end = valid_s && (col_r == COL_LAST);
    assign out_last    = valid_s && at_last_s;
    assign overrun     = overrun_r;
    assign frame_count = frame_count_r;

endmodule : pixel_readout

// File: tb/tb_pixel_readout.sv
// Directed self-checking bench for pixel_readout (W=3, H=2).
module tb_pixel_readout;
    import pixel_pkg::*;

    localparam int W = 3;
    localparam int H = 2;
    localparam int N = H * W;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [PIXEL_BITS*N-1:0] pixel_data_in;
    logic                    capture;
    logic [7:0]              out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_first;
    logic                    out_row_end;
    logic                    out_last;
    logic                    busy;
    logic                    overrun;
    logic                    overrun_clr;
    logic [15:0]             frame_count;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Hand-written expected byte streams and marker patterns for each pixel.
    logic [7:0] frame_a [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    logic [7:0] frame_b [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [7:0] frame_c [6] = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    logic       exp_first   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_row_end [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_last    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    pixel_readout #(.W(W), .H(H)) dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_data_in (pixel_data_in),
        .capture       (capture),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_first     (out_first),
        .out_row_end   (out_row_end),
        .out_last      (out_last),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .frame_count   (frame_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors_applied++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one full cycle; inputs change and outputs are sampled on negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_pixel(input string tag, input int k, input logic [7:0] exp_byte);
        check_val({tag, ".valid"},   out_valid,   1'b1);
        check_val({tag, ".data"},    out_data,    exp_byte);
        check_val({tag, ".first"},   out_first,   exp_first[k]);
        check_val({tag, ".row_end"}, out_row_end, exp_row_end[k]);
        check_val({tag, ".last"},    out_last,    exp_last[k]);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".valid"},   out_valid,   1'b0);
        check_val({tag, ".busy"},    busy,        1'b0);
        check_val({tag, ".first"},   out_first,   1'b0);
        check_val({tag, ".row_end"}, out_row_end, 1'b0);
        check_val({tag, ".last"},    out_last,    1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        capture = 1'b0;
        overrun_clr = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        pixel_data_in = '0;
        capture       = 1'b0;
        out_ready     = 1'b0;
        overrun_clr   = 1'b0;
        @(negedge clk);

        // ---- reset state ----
        apply_reset();
        check_idle("rst");
        check_val("rst.overrun", overrun, 1'b0);
        check_val("rst.fc", frame_count, 16'd0);
        check_val("rst.data", out_data, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("idle.valid", out_valid, 1'b0);
        end

        // ---- basic frame, ready held high ----
        pixel_data_in = 48'h605040302010;
        capture = 1'b1;
        out_ready = 1'b1;
        step();
        capture = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_pixel("basic", k, frame_a[k]);
            check_val("basic.busy", busy, 1'b1);
            step();
        end
        check_idle("basic.end");
        check_val("basic.fc", frame_count, 16'd1);

        // ---- backpressure: ready 1,0,0,1,0,0,... ----
        capture = 1'b1;
        step();
        capture = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            out_ready = ((cyc % 3) == 0);
            check_pixel("bp", n, frame_a[n]);
            if (out_ready) n++;
            step();
        end
        check_val("bp.count", n, 6);
        check_idle("bp.end");
        check_val("bp.fc", frame_count, 16'd2);

        // ---- overrun: second capture at third pixel is dropped ----
        out_ready = 1'b1;
        capture = 1'b1;
        step();
        capture = 1'b0;
        check_pixel("ovr", 0, frame_a[0]);
        step();
        check_pixel("ovr", 1, frame_a[1]);
        step();
        check_pixel("ovr", 2, frame_a[2]);
        pixel_data_in = 48'hFFFFFFFFFFFF;
        capture = 1'b1;
        step();
        capture = 1'b0;
        for (int k = 3; k < 6; k++) begin
            check_pixel("ovr.rest", k, frame_a[k]);
            check_val("ovr.flag", overrun, 1'b1);
            step();
        end
        check_idle("ovr.end");
        check_val("ovr.sticky", overrun, 1'b1);
        check_val("ovr.fc", frame_count, 16'd3);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_val("ovr.clr", overrun, 1'b0);

        // ---- clear coincident with another dropped capture: set wins ----
        pixel_data_in = 48'h605040302010;
        out_ready = 1'b0;
        capture = 1'b1;
        step();
        check_pixel("ovr2", 0, frame_a[0]);
        pixel_data_in = 48'hFFFFFFFFFFFF;
        capture = 1'b1;
        overrun_clr = 1'b1;
        step();
        capture = 1'b0;
        overrun_clr = 1'b0;
        check_val("ovr2.setwins", overrun, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_pixel("ovr2.drain", k, frame_a[k]);
            step();
        end
        check_idle("ovr2.end");
        check_val("ovr2.fc", frame_count, 16'd4);

        // ---- back-to-back frames with no bubble ----
        apply_reset();
        check_val("b2b.rst_fc", frame_count, 16'd0);
        check_val("b2b.rst_ovr", overrun, 1'b0);
        pixel_data_in = 48'h605040302010;
        out_ready = 1'b1;
        capture = 1'b1;
        step();
        capture = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_pixel("b2b.a", k, frame_a[k]);
            step();
        end
        check_pixel("b2b.a", 5, frame_a[5]);
        check_val("b2b.fc_a", frame_count, 16'd0);
        pixel_data_in = 48'hA5A5A5A5A5A5;
        capture = 1'b1;
        step();
        capture = 1'b0;
        check_val("b2b.fc1", frame_count, 16'd1);
        check_val("b2b.no_ovr", overrun, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check_pixel("b2b.b", k, frame_b[k]);
            step();
        end
        check_idle("b2b.end");
        check_val("b2b.fc2", frame_count, 16'd2);

        // ---- reset in the middle of a stream ----
        pixel_data_in = 48'h605040302010;
        capture = 1'b1;
        step();
        capture = 1'b0;
        check_pixel("mid", 0, frame_a[0]);
        step();
        check_pixel("mid", 1, frame_a[1]);
        step();
        reset = 1'b0;
        step();
        check_idle("mid.rst");
        check_val("mid.fc", frame_count, 16'd0);
        reset = 1'b1;
        pixel_data_in = 48'h0C0B0A090807;
        capture = 1'b1;
        step();
        capture = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_pixel("mid.new", k, frame_c[k]);
            step();
        end
        check_idle("mid.end");
        check_val("mid.fc1", frame_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_pixel_readout

// File: doc/pixel_readout.md
Name: pixel_readout

Overview:
- Consumer end of the pixel-array output bus: captures the parallel `pixelDataOut` word (8 bits per pixel) from `pixelTop` during the read phase.
- Streams the captured frame out one pixel per handshake, in row-major order, over a valid/ready byte interface.
- Sits between `pixelTop` and the off-chip/ADC-side interface logic.
- Buffers exactly one frame, so the pixel array is free for the next erase/expose cycle while readout drains.

Parameters:
- W, 3, pixel array width (columns)
- H, 2, pixel array height (rows)
- N, H*W, total pixels; bus width is 8*N

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- pixel_data_in  in  8*N  parallel frame from pixelTop; pixel k at bits [8k+7:8k], k = row*W+col
- capture  in  1  one-cycle strobe: pixel_data_in is stable and valid this cycle
- out_data  out  8  current pixel value
- out_valid  out  1  out_data/markers valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_first  out  1  current pixel is k=0
- out_row_end  out  1  current pixel has col==W-1
- out_last  out  1  current pixel is k=N-1
- busy  out  1  high while a frame is held (state STREAM)
- overrun  out  1  sticky: capture arrived while busy and was dropped
- overrun_clr  in  1  clears overrun
- frame_count  out  16  frames fully streamed, wraps 0xFFFF->0

Behaviour:
- Reset (reset==0 at an edge): state IDLE; out_valid=0, busy=0, overrun=0, frame_count=0, out_data=0, index/row/col=0. All markers are 0 because they are gated by out_valid. Reset mid-stream discards the held frame.
- States: IDLE, STREAM.
- IDLE:
  - capture=1 at an edge: shadow register <= pixel_data_in; idx<=0, col<=0, row<=0; enter STREAM.
  - out_valid rises the next cycle (latency 1 clk from capture to first pixel).
- STREAM:
  - out_valid=1 continuously.
  - out_data = shadow[8*idx +: 8].
  - out_data and markers hold stable until handshake.
  - On handshake with idx<N-1: idx+1; col+1, wrapping to 0 with row+1 when col==W-1.
  - On handshake with idx==N-1: frame_count+1; enter IDLE, out_valid=0 next cycle.
- Simultaneous last handshake and capture: reload shadow, idx=0, stay STREAM (back-to-back frame, no bubble). No overrun. frame_count still increments.
- capture in STREAM without a last handshake: capture ignored, shadow unchanged, overrun<=1.
- overrun_clr and a new overrun event in the same cycle: set wins (overrun=1).
- Markers are combinational from registered counters:
  - out_first = valid && idx==0
  - out_row_end = valid && col==W-1
  - out_last = valid && idx==N-1
- N=1: out_first, out_row_end and out_last are all high on the single pixel.
- Counter widths: idx is $clog2(N) bits (minimum 1); col/row are $clog2(W)/$clog2(H) bits (minimum 1). No arithmetic beyond increment; no saturation except frame_count wrap.
- out_ready is ignored when out_valid==0.

Decomposition:
- Shared package pixel_pkg:
  - PIXEL_BITS = 8
  - typedef enum {IDLE, STREAM} readout_state_t
  - typedef logic [PIXEL_BITS-1:0] pixel_t
- Single module, no sub-module. The byte select is a generated indexed part-select, not a separate mux block.

Test Plan:
- Reset: hold reset=0 for 3 clk, W=3, H=2 -> out_valid=0, busy=0, overrun=0, frame_count=0; release, idle 5 clk -> no output.
- Basic frame: pixel_data_in=0x605040302010, capture 1 clk, out_ready=1 -> from next cycle out_data 0x10,0x20,0x30,0x40,0x50,0x60 on consecutive cycles.
  - out_first on 0x10.
  - out_row_end on 0x30 and 0x60.
  - out_last on 0x60.
  - frame_count=1; busy drops after 0x60.
- Backpressure: same frame, out_ready toggling 1,0,0,1,... -> out_data/markers stable while out_ready=0; sequence is exactly 6 bytes, no drop or duplicate.
- Overrun: capture, then capture again at the 3rd pixel with data 0xFFFFFFFFFFFF -> remaining bytes 0x30..0x60 unchanged, overrun=1 sticky.
  - overrun_clr pulse -> overrun=0.
  - overrun_clr coincident with another dropped capture -> overrun stays 1.
- Back-to-back: capture frame B=0xA5A5A5A5A5A5 in the same cycle as frame A's last handshake -> next cycle out_data=0xA5 with out_first=1, no idle cycle, frame_count=1 then 2.
- Reset mid-stream: reset=0 after 2nd pixel -> next cycle out_valid=0, frame_count=0; new capture after release streams from pixel 0.
